stage5_field_extract: RTL and testbench

Parametrised, pipelined field extractor for decoded market-data messages in the stage-5 field stage. Each of NUM_CH channels accepts a message beat plus its message-type code, looks up a runtime-programmed bit offset for that type, and emits the selected field, or DEFAULT_INFO on a miss, through a 2-stage valid/ready pipeline. Per-channel saturating hit counters support line-rate monitoring. The block replaces the fixed-offset, fixed-type, three-channel combinational field selectors.

---
 rtl/stage5_field_extract_if.sv | 27 ++
 rtl/stage5_field_extract.sv | 132 +++++++++++++
 tb/tb_stage5_field_extract.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage5_field_extract_if.sv
// Per-channel message-in / field-out stream bundle for the stage-5 field extractor.
// The slave side is the extractor; the master side is the surrounding datapath.
interface stage5_field_extract_if #(
  parameter int NUM_CH     = 3,
  parameter int MSG_BITS   = 64,
  parameter int FIELD_BITS = 16,
  parameter int MUX_W      = 3
);
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [NUM_CH*MSG_BITS-1:0]   in_msg;
  logic [NUM_CH*MUX_W-1:0]      in_type;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH-1:0]            out_ready;
  logic [NUM_CH*FIELD_BITS-1:0] out_field;
  logic [NUM_CH-1:0]            out_hit;

  modport master (
    output in_valid, in_msg, in_type, out_ready,
    input  in_ready, out_valid, out_field, out_hit
  );

  modport slave (
    input  in_valid, in_msg, in_type, out_ready,
    output in_ready, out_valid, out_field, out_hit
  );
endinterface

// File: rtl/stage5_field_extract.sv
// Multi-channel field extractor: runtime offset table lookup per message type,
// 2-stage valid/ready pipeline per channel, saturating per-channel hit counters.
module stage5_field_extract #(
  parameter int                    NUM_CH       = 3,
  parameter int                    MSG_BITS     = 64,
  parameter int                    FIELD_BITS   = 16,
  parameter int                    MUX_W        = 3,
  parameter int                    OFF_W        = 6,
  parameter int                    CNT_W        = 16,
  parameter logic [FIELD_BITS-1:0] DEFAULT_INFO = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msg_en,
  stage5_field_extract_if.slave   bus,
  input  logic                    cfg_we,
  input  logic [MUX_W-1:0]        cfg_type,
  input  logic                    cfg_en,
  input  logic [OFF_W-1:0]        cfg_off,
  output logic                    cfg_err,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt,
  input  logic                    cnt_clr
);
  localparam int               TAB_N   = 1 << MUX_W;
  localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(MSG_BITS - FIELD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TAB_N-1:0] tab_en_reg;
  logic [OFF_W-1:0] tab_off_reg [TAB_N];
  logic             cfg_err_reg;
  logic             cfg_ok;

  // Offsets that would run the field past the top of the message are refused.
  assign cfg_ok  = (cfg_off <= MAX_OFF);
  assign cfg_err = cfg_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tab_en_reg  <= '0;
      cfg_err_reg <= 1'b0;
      for (int i = 0; i < TAB_N; i++) begin
        tab_off_reg[i] <= '0;
      end
    end else begin
      cfg_err_reg <= cfg_we & ~cfg_ok;
      if (cfg_we && cfg_ok) begin
        tab_en_reg[cfg_type]  <= cfg_en;
        tab_off_reg[cfg_type] <= cfg_off;
      end
    end
  end

  logic [NUM_CH-1:0]            in_ready_vec;
  logic [NUM_CH-1:0]            out_valid_vec;
  logic [NUM_CH*FIELD_BITS-1:0] out_field_vec;
  logic [NUM_CH-1:0]            out_hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                  s1_valid_reg;
      logic [MSG_BITS-1:0]   s1_msg_reg;
      logic                  s1_hit_reg;
      logic [OFF_W-1:0]      s1_off_reg;
      logic                  out_valid_reg;
      logic [FIELD_BITS-1:0] out_field_reg;
      logic                  out_hit_reg;
      logic [CNT_W-1:0]      cnt_reg;
      logic                  s2_load;
      logic                  in_ready_c;
      logic [MUX_W-1:0]      type_c;
      logic [MSG_BITS-1:0]   shifted;

      assign type_c     = bus.in_type[gi*MUX_W +: MUX_W];
      assign s2_load    = s1_valid_reg & (~out_valid_reg | bus.out_ready[gi]);
      assign in_ready_c = ~s1_valid_reg | s2_load;
      assign shifted    = s1_msg_reg >> s1_off_reg;

      // Table entry and enable are frozen at acceptance so later writes never touch in-flight beats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_reg <= 1'b0;
          s1_msg_reg   <= '0;
          s1_hit_reg   <= 1'b0;
          s1_off_reg   <= '0;
        end else if (in_ready_c) begin
          s1_valid_reg <= bus.in_valid[gi];
          if (bus.in_valid[gi]) begin
            s1_msg_reg <= bus.in_msg[gi*MSG_BITS +: MSG_BITS];
            s1_hit_reg <= msg_en & tab_en_reg[type_c];
            s1_off_reg <= tab_off_reg[type_c];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_reg <= 1'b0;
          out_field_reg <= DEFAULT_INFO;
          out_hit_reg   <= 1'b0;
        end else if (s2_load) begin
          out_valid_reg <= 1'b1;
          out_field_reg <= s1_hit_reg ? shifted[FIELD_BITS-1:0] : DEFAULT_INFO;
          out_hit_reg   <= s1_hit_reg;
        end else if (bus.out_ready[gi]) begin
          out_valid_reg <= 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (out_valid_reg && bus.out_ready[gi] && out_hit_reg && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign in_ready_vec[gi]                             = in_ready_c;
      assign out_valid_vec[gi]                            = out_valid_reg;
      assign out_field_vec[gi*FIELD_BITS +: FIELD_BITS]   = out_field_reg;
      assign out_hit_vec[gi]                              = out_hit_reg;
      assign hit_cnt[gi*CNT_W +: CNT_W]                   = cnt_reg;
    end
  endgenerate

  assign bus.in_ready  = in_ready_vec;
  assign bus.out_valid = out_valid_vec;
  assign bus.out_field = out_field_vec;
  assign bus.out_hit   = out_hit_vec;
endmodule

// File: tb/tb_stage5_field_extract.sv
// Bench for stage5_field_extract: table-driven vectors plus a per-channel scoreboard
// fed at acceptance and drained when output beats transfer.
`timescale 1ns/1ps
module tb_stage5_field_extract;
  localparam int NUM_CH     = 3;
  localparam int MSG_BITS   = 64;
  localparam int FIELD_BITS = 16;
  localparam int MUX_W      = 3;
  localparam int OFF_W      = 6;
  localparam int CNT_W      = 16;

  typedef struct {
    logic [MUX_W-1:0]      typ;
    logic [MSG_BITS-1:0]   msg;
    logic [FIELD_BITS-1:0] exp_field;
    logic                  exp_hit;
  } beat_t;

  typedef struct {
    logic [FIELD_BITS-1:0] exp_field;
    logic                  exp_hit;
    int                    acc_cyc;
  } exp_t;

  typedef struct {
    int                    ch;
    logic [MUX_W-1:0]      typ;
    logic [MSG_BITS-1:0]   msg;
    logic                  en;
    logic [FIELD_BITS-1:0] exp_field;
    logic                  exp_hit;
  } vec_t;

  logic                    clk;
  logic                    rst_n;
  logic                    msg_en;
  logic                    cfg_we;
  logic [MUX_W-1:0]        cfg_type;
  logic                    cfg_en;
  logic [OFF_W-1:0]        cfg_off;
  logic                    cfg_err;
  logic [NUM_CH*CNT_W-1:0] hit_cnt;
  logic                    cnt_clr;

  stage5_field_extract_if #(
    .NUM_CH(NUM_CH), .MSG_BITS(MSG_BITS), .FIELD_BITS(FIELD_BITS), .MUX_W(MUX_W)
  ) bus_if ();

  stage5_field_extract dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .msg_en   (msg_en),
    .bus      (bus_if),
    .cfg_we   (cfg_we),
    .cfg_type (cfg_type),
    .cfg_en   (cfg_en),
    .cfg_off  (cfg_off),
    .cfg_err  (cfg_err),
    .hit_cnt  (hit_cnt),
    .cnt_clr  (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  bit    chk_lat   = 0;
  bit    bulk      = 0;
  beat_t stim_q [NUM_CH][$];
  exp_t  sb_q   [NUM_CH][$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic push(int c, logic [MUX_W-1:0] t, logic [MSG_BITS-1:0] m,
                      logic [FIELD_BITS-1:0] f, logic h);
    beat_t b;
    b.typ = t; b.msg = m; b.exp_field = f; b.exp_hit = h;
    stim_q[c].push_back(b);
  endtask

  task automatic cfg_write(logic [MUX_W-1:0] t, logic e, logic [OFF_W-1:0] o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_type = t; cfg_en = e; cfg_off = o;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(int maxc, string name);
    bit done;
    done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      #3;
      if (stim_q[0].size() == 0 && stim_q[1].size() == 0 && stim_q[2].size() == 0 &&
          sb_q[0].size() == 0 && sb_q[1].size() == 0 && sb_q[2].size() == 0 &&
          bus_if.out_valid == '0)
        done = 1;
    end
    chk(name, 64'(done), 64'(1));
  endtask

  // Driver and monitor: present stimulus just after the falling edge, then evaluate
  // both handshakes (which complete on the coming rising edge).
  logic                  prev_stall [NUM_CH];
  logic [FIELD_BITS-1:0] prev_field [NUM_CH];
  logic                  prev_hit   [NUM_CH];

  initial begin
    beat_t                 b;
    exp_t                  e;
    logic [FIELD_BITS-1:0] fld;
    bus_if.in_valid = '0;
    bus_if.in_msg   = '0;
    bus_if.in_type  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prev_stall[c] = 1'b0; prev_field[c] = '0; prev_hit[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (stim_q[c].size() > 0) begin
          bus_if.in_valid[c]                        = 1'b1;
          bus_if.in_msg[c*MSG_BITS +: MSG_BITS]     = stim_q[c][0].msg;
          bus_if.in_type[c*MUX_W +: MUX_W]          = stim_q[c][0].typ;
        end else begin
          bus_if.in_valid[c] = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        fld = bus_if.out_field[c*FIELD_BITS +: FIELD_BITS];
        if (prev_stall[c] && rst_n) begin
          chk("stall_valid", 64'(bus_if.out_valid[c]), 64'(1));
          chk("stall_field", 64'(fld), 64'(prev_field[c]));
          chk("stall_hit", 64'(bus_if.out_hit[c]), 64'(prev_hit[c]));
        end
        if (rst_n && bus_if.out_valid[c] && bus_if.out_ready[c]) begin
          if (sb_q[c].size() == 0) begin
            chk("unexpected_beat", 64'(bus_if.out_valid[c]), 64'(0));
          end else begin
            e = sb_q[c].pop_front();
            chk("out_field", 64'(fld), 64'(e.exp_field));
            chk("out_hit", 64'(bus_if.out_hit[c]), 64'(e.exp_hit));
            if (chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(2));
            if (!bulk)
              $display("ch%0d out field=%h hit=%b (exp %h/%b) cycle %0d",
                       c, fld, bus_if.out_hit[c], e.exp_field, e.exp_hit, cyc);
          end
        end
        prev_stall[c] = rst_n && bus_if.out_valid[c] && !bus_if.out_ready[c];
        prev_field[c] = fld;
        prev_hit[c]   = bus_if.out_hit[c];
        if (rst_n && bus_if.in_valid[c] && bus_if.in_ready[c] && stim_q[c].size() > 0) begin
          b = stim_q[c].pop_front();
          e.exp_field = b.exp_field; e.exp_hit = b.exp_hit; e.acc_cyc = cyc;
          sb_q[c].push_back(e);
        end
      end
    end
  end

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 3'd3, 64'h0000_0000_00AB_CD00, 1'b1, 16'hABCD, 1'b1};
    vecs[1] = '{0, 3'd5, 64'h0000_0000_00AB_CD00, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{0, 3'd3, 64'h0000_0000_00AB_CD00, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1, 3'd3, 64'h1234_5678_9ABC_DEF0, 1'b1, 16'hBCDE, 1'b1};
    vecs[4] = '{2, 3'd3, 64'hFFFF_FFFF_FFFF_00FF, 1'b1, 16'hFF00, 1'b1};
    vecs[5] = '{2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'h0000, 1'b0};

    rst_n = 1'b0; msg_en = 1'b1; cfg_we = 1'b0; cfg_type = '0; cfg_en = 1'b0;
    cfg_off = '0; cnt_clr = 1'b0; bus_if.out_ready = '1;

    // Reset state
    #22;
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
    chk("rst_out_hit", 64'(bus_if.out_hit), 64'(0));
    chk("rst_out_field", 64'(bus_if.out_field), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'(3'b111));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(bus_if.in_ready), 64'(3'b111));

    // Table-driven vectors
    cfg_write(3'd3, 1'b1, 6'd8);
    chk_lat = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      msg_en = vecs[i].en;
      push(vecs[i].ch, vecs[i].typ, vecs[i].msg, vecs[i].exp_field, vecs[i].exp_hit);
      wait_idle(12, "vec_idle");
    end
    chk_lat = 0;
    msg_en  = 1'b1;
    chk("hit_cnt0_vecs", 64'(hit_cnt[0*CNT_W +: CNT_W]), 64'(1));
    chk("hit_cnt1_vecs", 64'(hit_cnt[1*CNT_W +: CNT_W]), 64'(1));
    chk("hit_cnt2_vecs", 64'(hit_cnt[2*CNT_W +: CNT_W]), 64'(1));

    // Config error, then boundary offset
    @(negedge clk);
    cfg_we = 1'b1; cfg_type = 3'd3; cfg_en = 1'b1; cfg_off = 6'd50;
    chk("cfg_err_idle", 64'(cfg_err), 64'(0));
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'(1));
    @(negedge clk);
    chk("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
    push(0, 3'd3, 64'h0000_0000_00AB_CD00, 16'hABCD, 1'b1);
    wait_idle(12, "cfg_rej_idle");
    cfg_write(3'd6, 1'b1, 6'd48);
    chk("cfg_err_ok48", 64'(cfg_err), 64'(0));
    @(negedge clk);
    push(0, 3'd6, 64'hDEAD_0000_0000_0000, 16'hDEAD, 1'b1);
    wait_idle(12, "off48_idle");

    // Backpressure on ch1 while ch0/ch2 stream
    @(negedge clk);
    bus_if.out_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++)
      push(1, 3'd3, {40'h0, 16'hB000 + 16'(i), 8'h00}, 16'hB000 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) begin
      push(0, 3'd3, {40'h0, 16'hC000 + 16'(i), 8'h00}, 16'hC000 + 16'(i), 1'b1);
      push(2, 3'd3, {40'h0, 16'hD000 + 16'(i), 8'h00}, 16'hD000 + 16'(i), 1'b1);
    end
    repeat (12) @(negedge clk);
    #3;
    chk("bp_accepted", 64'(sb_q[1].size()), 64'(2));
    chk("bp_waiting", 64'(stim_q[1].size()), 64'(2));
    chk("bp_in_ready", 64'(bus_if.in_ready[1]), 64'(0));
    chk("bp_out_valid", 64'(bus_if.out_valid[1]), 64'(1));
    chk("bp_ch0_drained", 64'(stim_q[0].size() + sb_q[0].size()), 64'(0));
    chk("bp_ch2_drained", 64'(stim_q[2].size() + sb_q[2].size()), 64'(0));
    @(negedge clk);
    bus_if.out_ready[1] = 1'b1;
    #2;
    chk("bp_release_ready", 64'(bus_if.in_ready[1]), 64'(1));
    wait_idle(20, "bp_idle");

    // Config write colliding with an accept of the same type
    @(negedge clk);
    cfg_we = 1'b1; cfg_type = 3'd3; cfg_en = 1'b1; cfg_off = 6'd0;
    push(0, 3'd3, 64'h0000_0000_00AB_CD00, 16'hABCD, 1'b1);
    @(negedge clk);
    cfg_we = 1'b0;
    push(0, 3'd3, 64'h0000_0000_00AB_CD00, 16'hCD00, 1'b1);
    wait_idle(12, "collide_idle");

    // Counter saturation
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr_all", 64'(hit_cnt), 64'(0));
    bulk = 1;
    for (int i = 0; i < 65537; i++)
      push(0, 3'd3, 64'(i), 16'(i), 1'b1);
    wait_idle(70000, "bulk_idle");
    bulk = 0;
    $display("bulk stream of 65537 hits on ch0 complete, hit_cnt0=%h", hit_cnt[0 +: CNT_W]);
    chk("hit_cnt_sat", 64'(hit_cnt[0 +: CNT_W]), 64'(16'hFFFF));

    // Clear concurrent with a hit transfer
    @(negedge clk);
    push(0, 3'd3, 64'h0000_0000_0000_1234, 16'h1234, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("clr_hit_present", 64'(bus_if.out_valid[0]), 64'(1));
    chk("sat_hold", 64'(hit_cnt[0 +: CNT_W]), 64'(16'hFFFF));
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_wins", 64'(hit_cnt[0 +: CNT_W]), 64'(0));
    wait_idle(12, "clr_idle");

    // Async reset with ch1 pipeline full
    @(negedge clk);
    bus_if.out_ready[1] = 1'b0;
    for (int i = 0; i < 3; i++)
      push(1, 3'd3, {48'h0, 16'hE000 + 16'(i)}, 16'hE000 + 16'(i), 1'b1);
    repeat (4) @(negedge clk);
    #3;
    chk("pre_rst_full", 64'(bus_if.out_valid[1]), 64'(1));
    chk("pre_rst_stall", 64'(bus_if.in_ready[1]), 64'(0));
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      stim_q[c].delete();
      sb_q[c].delete();
    end
    #1;
    chk("arst_out_valid", 64'(bus_if.out_valid), 64'(0));
    chk("arst_out_hit", 64'(bus_if.out_hit), 64'(0));
    chk("arst_out_field", 64'(bus_if.out_field), 64'(0));
    chk("arst_in_ready", 64'(bus_if.in_ready), 64'(3'b111));
    chk("arst_hit_cnt", 64'(hit_cnt), 64'(0));
    bus_if.out_ready = '1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("post_rst_quiet", 64'(bus_if.out_valid), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
